// File: rtl/debug_dumper.sv
// Debug command sequencer: run/halt/step control of a CPU plus a ranged dump
// of probe registers, streamed out one word at a time with valid/ready.
module debug_dumper #(
   parameter int unsigned READ_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [6:0]  cmd_first,
   input  logic [6:0]  cmd_last,
   output logic        debug_en,
   output logic        debug_step,
   output logic [6:0]  debug_addr,
   input  logic [31:0] debug_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_addr,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy
);

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LAT_W  = 3;
   // Settle countdown starts at READ_LAT-1 so SETTLE spans exactly READ_LAT cycles
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

   localparam logic [1:0] OP_RUN  = 2'b00;
   localparam logic [1:0] OP_HALT = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_DUMP = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STEP   = 3'd1,
      SETTLE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   last_q, last_nxt;
   logic [LAT_W-1:0]    lat_cnt, lat_nxt;
   logic                en_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic                ov_nxt;
   logic [ADDR_W-1:0]   oa_nxt;
   logic [DATA_W-1:0]   od_nxt;
   logic                ol_nxt;

   // Next-state and next-register values
   always_comb begin
      state_nxt = state;
      en_nxt    = debug_en;
      addr_nxt  = debug_addr;
      last_nxt  = last_q;
      lat_nxt   = lat_cnt;
      ov_nxt    = out_valid;
      oa_nxt    = out_addr;
      od_nxt    = out_data;
      ol_nxt    = out_last;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_RUN:  en_nxt = 1'b0;
                  OP_HALT: en_nxt = 1'b1;
                  OP_STEP: begin
                     en_nxt    = 1'b1;
                     state_nxt = STEP;
                  end
                  OP_DUMP: begin
                     addr_nxt  = cmd_first;
                     last_nxt  = cmd_last;
                     lat_nxt   = LAT_LOAD;
                     state_nxt = SETTLE;
                  end
                  default: state_nxt = IDLE;
               endcase
            end
         end

         STEP: state_nxt = IDLE;

         SETTLE: begin
            if (lat_cnt == '0) begin
               ov_nxt    = 1'b1;
               oa_nxt    = debug_addr;
               od_nxt    = debug_data;
               ol_nxt    = (debug_addr == last_q);
               state_nxt = HOLD;
            end else begin
               lat_nxt = lat_cnt - LAT_W'(1);
            end
         end

         HOLD: begin
            if (out_ready) begin
               ov_nxt = 1'b0;
               if (out_last) begin
                  state_nxt = DONE;
               end else begin
                  // 7-bit add wraps 127 -> 0 for ranges with first > last
                  addr_nxt  = debug_addr + ADDR_W'(1);
                  lat_nxt   = LAT_LOAD;
                  state_nxt = SETTLE;
               end
            end
         end

         DONE: state_nxt = IDLE;

         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers; status outputs decode the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         debug_en   <= 1'b0;
         debug_step <= 1'b0;
         debug_addr <= '0;
         last_q     <= '0;
         lat_cnt    <= '0;
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         cmd_ready  <= 1'b1;
      end else begin
         state      <= state_nxt;
         debug_en   <= en_nxt;
         debug_step <= (state_nxt == STEP);
         debug_addr <= addr_nxt;
         last_q     <= last_nxt;
         lat_cnt    <= lat_nxt;
         out_valid  <= ov_nxt;
         out_addr   <= oa_nxt;
         out_data   <= od_nxt;
         out_last   <= ol_nxt;
         busy       <= (state_nxt != IDLE);
         cmd_ready  <= (state_nxt == IDLE);
      end
   end

endmodule

// File: doc/debug_dumper.md
DEBUG_DUMPER -- requirements
Module: debug_dumper

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1, meaning the cycles from a debug_addr change to valid debug_data (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: a command is accepted.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: 00 run, 01 halt, 10 step, 11 dump.
REQ-007 The block SHALL have port cmd_first, input, 7 bits: the first dump address.
REQ-008 The block SHALL have port cmd_last, input, 7 bits: the last dump address, inclusive.
REQ-009 The block SHALL have port debug_en, output, 1 bit: holds the CPU halted under debug control.
REQ-010 The block SHALL have port debug_step, output, 1 bit: a single-cycle step pulse.
REQ-011 The block SHALL have port debug_addr, output, 7 bits: the debug register/probe index.
REQ-012 The block SHALL have port debug_data, input, 32 bits: the probe value returned by the CPU.
REQ-013 The block SHALL have port out_valid, output, 1 bit: a dumped word is available.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the sink accepts the word.
REQ-015 The block SHALL have port out_addr, output, 7 bits: the address of the dumped word.
REQ-016 The block SHALL have port out_data, output, 32 bits: the dumped word.
REQ-017 The block SHALL have port out_last, output, 1 bit: marks the final word of the dump.
REQ-018 The block SHALL have port busy, output, 1 bit: the block is not in IDLE.

Function
REQ-019 The block SHALL implement states IDLE, STEP, SETTLE, HOLD, and DONE.
REQ-020 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on a clk edge with cmd_valid=1 and cmd_ready=1.
REQ-021 On acceptance, cmd_first and cmd_last SHALL be latched; later input changes SHALL have no effect.
REQ-022 Run SHALL clear debug_en on the next edge and stay in IDLE.
REQ-023 Halt SHALL set debug_en on the next edge and stay in IDLE.
REQ-024 Step SHALL set debug_en, enter STEP, and assert debug_step for exactly one cycle, then return to IDLE.
REQ-025 Step SHALL keep debug_en=1 afterward, and SHALL be legal whether or not the CPU was halted.
REQ-026 Dump SHALL NOT change debug_en.
REQ-027 Dump SHALL load the address counter with first and enter SETTLE; debug_addr SHALL be driven from the counter.
REQ-028 SETTLE SHALL last READ_LAT cycles, then capture debug_data, counter, and last flag into the output registers, and enter HOLD with out_valid=1.
REQ-029 In HOLD, out_valid, out_addr, out_data, and out_last SHALL remain stable until out_ready=1.
REQ-030 On a HOLD transfer that is not last, the counter SHALL increment modulo 128 and the block SHALL re-enter SETTLE.
REQ-031 On a HOLD transfer that is last, the block SHALL go to DONE, then IDLE one cycle later.
REQ-032 The minimum cost SHALL be READ_LAT+1 cycles per word.
REQ-033 A word SHALL be last when the counter equals the latched last address.
REQ-034 If first > last, the dump SHALL wrap 127 to 0; word count = ((last - first) mod 128) + 1.
REQ-035 first = last SHALL yield a single word with out_last=1.
REQ-036 first = 0 with last = 127 SHALL yield 128 words.
REQ-037 out_ready held at 1 while out_valid=0 SHALL have no effect.
REQ-038 out_ready held low indefinitely SHALL stall the block in HOLD with no data loss.
REQ-039 cmd_valid asserted while busy SHALL be ignored, not queued; the initiator retries.
REQ-040 busy SHALL equal 0 only in IDLE.

Reset
REQ-041 While rst=0, the block SHALL go to IDLE immediately, independent of clk.
REQ-042 While rst=0, debug_en, debug_step, debug_addr, out_valid, out_last, out_addr, out_data, and busy SHALL be 0, and cmd_ready SHALL be 1.
REQ-043 Reset mid-dump SHALL abort the dump; no further words SHALL be emitted and out_valid SHALL drop asynchronously.
REQ-044 Reset mid-step SHALL truncate debug_step immediately.

Verification
REQ-045 Reset release, then halt, then step -> debug_en=1 from the halt edge; exactly one debug_step cycle; busy high one cycle; cmd_ready returns to 1.
REQ-046 Dump first=3, last=5, out_ready=1, READ_LAT=1, with debug_data = addr*16 -> words (3,0x30), (4,0x40), (5,0x50); out_last only on 5; 2 cycles per word.
REQ-047 Dump first=126, last=1 -> addresses 126, 127, 0, 1 in order; out_last on 1; 4 words total.
REQ-048 Dump first=last=9 with out_ready low 10 cycles -> out_valid held 10 cycles with stable data 0x90; a single transfer with out_last=1.
REQ-049 Dump 0..127 with rst pulsed low at word 40 while HOLD -> outputs zero immediately; no word 41; after release, cmd_ready=1 and debug_en=0.
REQ-050 Halt issued while a dump is busy -> command ignored; debug_en unchanged; dump completes normally.
